// File: rtl/user_stream_pkg.sv
// ==== user_stream_pkg : shared constants and width helpers for the stream adapter ====
// ==== rev 1.0 ====
`default_nettype none

package user_stream_pkg;

  localparam int USER_DATA_W = 64;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Level counts 0..depth inclusive, hence one bit wider than a pointer.
  function automatic int lvl_w(input int depth);
    return clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_fifo_fwft.sv
// ==== stream_fifo_fwft : first-word-fall-through FIFO with enable, flush, level and almost-full ====
// ==== rev 1.0 ====
`default_nettype none

module stream_fifo_fwft
  import user_stream_pkg::*;
#(
  parameter  int DATA_W   = USER_DATA_W,
  parameter  int DEPTH    = 16,
  parameter  int AFULL_TH = 12,
  localparam int LVL_W    = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic              push_valid,
  output logic              push_ack,
  input  logic [DATA_W-1:0] push_data,
  output logic              pop_valid,
  input  logic              pop_ack,
  output logic [DATA_W-1:0] pop_data,
  output logic [LVL_W-1:0]  level,
  output logic              afull
);

  localparam int               C_AW    = LVL_W - 1;
  localparam logic [LVL_W-1:0] C_DEPTH = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] C_AFULL = LVL_W'(AFULL_TH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [C_AW-1:0]   r_wr_ptr;
  logic [C_AW-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [LVL_W-1:0]  w_level_nxt;
  logic              r_afull;
  logic              r_active;
  logic              w_open;
  logic              w_push;
  logic              w_pop;

  // r_active keeps both handshakes low in the first cycle after a reset edge.
  assign w_open    = r_active & enable & ~flush;
  assign push_ack  = w_open & (r_level != C_DEPTH);
  assign pop_valid = w_open & (r_level != '0);
  assign w_push    = push_valid & push_ack;
  assign w_pop     = pop_valid & pop_ack;
  assign pop_data  = r_mem[r_rd_ptr];
  assign level     = r_level;
  assign afull     = r_afull;

  always_comb begin
    w_level_nxt = r_level;
    if (flush) begin
      w_level_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_afull  <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + C_AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + C_AW'(1);
      end
      r_level <= w_level_nxt;
      r_afull <= (w_level_nxt >= C_AFULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/user_stream_adapter_mc.sv
// ==== user_stream_adapter_mc : NUM_CH-channel bidirectional FIFO adapter, PCIe stream <-> user logic ====
// ==== rev 1.0 ====
`default_nettype none

module user_stream_adapter_mc
  import user_stream_pkg::*;
#(
  parameter  int NUM_CH   = 4,
  parameter  int DATA_W   = USER_DATA_W,
  parameter  int DEPTH    = 16,
  parameter  int AFULL_TH = 12,
  localparam int LVL_W    = lvl_w(DEPTH)
) (
  input  logic                       i_user_clk,
  input  logic                       i_rst,
  input  logic [NUM_CH-1:0]          i_ch_enable,
  input  logic [NUM_CH-1:0]          i_ch_flush,
  input  logic [NUM_CH-1:0]          i_pcie_str_data_valid,
  output logic [NUM_CH-1:0]          o_pcie_str_ack,
  input  logic [NUM_CH*DATA_W-1:0]   i_pcie_str_data,
  output logic [NUM_CH-1:0]          o_pcie_str_data_valid,
  input  logic [NUM_CH-1:0]          i_pcie_str_ack,
  output logic [NUM_CH*DATA_W-1:0]   o_pcie_str_data,
  output logic [NUM_CH-1:0]          o_ul_str_data_valid,
  input  logic [NUM_CH-1:0]          i_ul_str_ack,
  output logic [NUM_CH*DATA_W-1:0]   o_ul_str_data,
  input  logic [NUM_CH-1:0]          i_ul_str_data_valid,
  output logic [NUM_CH-1:0]          o_ul_str_ack,
  input  logic [NUM_CH*DATA_W-1:0]   i_ul_str_data,
  output logic [NUM_CH*LVL_W-1:0]    o_h2u_level,
  output logic [NUM_CH*LVL_W-1:0]    o_u2h_level,
  output logic [NUM_CH-1:0]          o_h2u_afull,
  output logic [NUM_CH-1:0]          o_u2h_afull
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Host to user: PCIe engine pushes, user logic pops.
    stream_fifo_fwft #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AFULL_TH (AFULL_TH)
    ) u_h2u (
      .clk        (i_user_clk),
      .rst_n      (i_rst),
      .enable     (i_ch_enable[k]),
      .flush      (i_ch_flush[k]),
      .push_valid (i_pcie_str_data_valid[k]),
      .push_ack   (o_pcie_str_ack[k]),
      .push_data  (i_pcie_str_data[k*DATA_W +: DATA_W]),
      .pop_valid  (o_ul_str_data_valid[k]),
      .pop_ack    (i_ul_str_ack[k]),
      .pop_data   (o_ul_str_data[k*DATA_W +: DATA_W]),
      .level      (o_h2u_level[k*LVL_W +: LVL_W]),
      .afull      (o_h2u_afull[k])
    );

    // User to host: user logic pushes, PCIe engine pops.
    stream_fifo_fwft #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .AFULL_TH (AFULL_TH)
    ) u_u2h (
      .clk        (i_user_clk),
      .rst_n      (i_rst),
      .enable     (i_ch_enable[k]),
      .flush      (i_ch_flush[k]),
      .push_valid (i_ul_str_data_valid[k]),
      .push_ack   (o_ul_str_ack[k]),
      .push_data  (i_ul_str_data[k*DATA_W +: DATA_W]),
      .pop_valid  (o_pcie_str_data_valid[k]),
      .pop_ack    (i_pcie_str_ack[k]),
      .pop_data   (o_pcie_str_data[k*DATA_W +: DATA_W]),
      .level      (o_u2h_level[k*LVL_W +: LVL_W]),
      .afull      (o_u2h_afull[k])
    );
  end : g_ch

endmodule

`default_nettype wire

// File: tb/tb_user_stream_adapter_mc.sv
// ==== tb_user_stream_adapter_mc : randomized and directed bench with a queue-based reference model ====
// ==== rev 1.0 ====
`default_nettype none

module tb_user_stream_adapter_mc;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 64;
  localparam int DEPTH    = 16;
  localparam int AFULL_TH = 12;
  localparam int LVL_W    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic [NUM_CH-1:0]        en, flush, pv, pa, uv, ua;
  logic [NUM_CH*DATA_W-1:0] pd, ud;
  logic [NUM_CH-1:0]        o_pcie_str_ack, o_pcie_str_data_valid, o_ul_str_data_valid, o_ul_str_ack;
  logic [NUM_CH*DATA_W-1:0] o_pcie_str_data, o_ul_str_data;
  logic [NUM_CH*LVL_W-1:0]  o_h2u_level, o_u2h_level;
  logic [NUM_CH-1:0]        o_h2u_afull, o_u2h_afull;

  user_stream_adapter_mc #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)
  ) dut (
    .i_user_clk            (clk),
    .i_rst                 (rst_n),
    .i_ch_enable           (en),
    .i_ch_flush            (flush),
    .i_pcie_str_data_valid (pv),
    .o_pcie_str_ack        (o_pcie_str_ack),
    .i_pcie_str_data       (pd),
    .o_pcie_str_data_valid (o_pcie_str_data_valid),
    .i_pcie_str_ack        (pa),
    .o_pcie_str_data       (o_pcie_str_data),
    .o_ul_str_data_valid   (o_ul_str_data_valid),
    .i_ul_str_ack          (ua),
    .o_ul_str_data         (o_ul_str_data),
    .i_ul_str_data_valid   (uv),
    .o_ul_str_ack          (o_ul_str_ack),
    .i_ul_str_data         (ud),
    .o_h2u_level           (o_h2u_level),
    .o_u2h_level           (o_u2h_level),
    .o_h2u_afull           (o_h2u_afull),
    .o_u2h_afull           (o_u2h_afull)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s ch%0d: got %h expected %h at %0t", name, ch, act, exp, $time);
    end
  endtask

  // Reference model: one word queue per channel and direction.
  logic [DATA_W-1:0] mq_h2u [NUM_CH][$];
  logic [DATA_W-1:0] mq_u2h [NUM_CH][$];
  logic [DATA_W-1:0] out2 [$];
  logic [DATA_W-1:0] w_tmp;
  bit m_active = 1'b0;
  bit started  = 1'b0;
  bit acc_p [NUM_CH];
  bit acc_u [NUM_CH];
  int m_pops [NUM_CH];
  bit hpush, hpop, upush, upop;

  always @(posedge clk) begin
    if (!rst_n) begin
      started  = 1'b1;
      m_active = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        mq_h2u[c].delete();
        mq_u2h[c].delete();
        acc_p[c] = 1'b0;
        acc_u[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc_p[c] = 1'b0;
        acc_u[c] = 1'b0;
        if (flush[c]) begin
          mq_h2u[c].delete();
          mq_u2h[c].delete();
        end else if (m_active && en[c]) begin
          hpush = pv[c] && (mq_h2u[c].size() < DEPTH);
          hpop  = ua[c] && (mq_h2u[c].size() > 0);
          upush = uv[c] && (mq_u2h[c].size() < DEPTH);
          upop  = pa[c] && (mq_u2h[c].size() > 0);
          if (hpop) begin
            void'(mq_h2u[c].pop_front());
            m_pops[c]++;
          end
          if (hpush) mq_h2u[c].push_back(pd[c*DATA_W +: DATA_W]);
          if (upop) begin
            w_tmp = mq_u2h[c].pop_front();
            if (c == 2) out2.push_back(w_tmp);
          end
          if (upush) mq_u2h[c].push_back(ud[c*DATA_W +: DATA_W]);
          acc_p[c] = hpush;
          acc_u[c] = upush;
        end
      end
      m_active = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int c = 0; c < NUM_CH; c++) begin
        automatic bit open = m_active && en[c] && !flush[c];
        automatic int hs   = mq_h2u[c].size();
        automatic int us   = mq_u2h[c].size();
        check("h2u_ack",   c, 64'(o_pcie_str_ack[c]),      64'(open && hs < DEPTH));
        check("h2u_valid", c, 64'(o_ul_str_data_valid[c]), 64'(open && hs > 0));
        if (open && hs > 0) check("h2u_data", c, o_ul_str_data[c*DATA_W +: DATA_W], mq_h2u[c][0]);
        check("h2u_level", c, 64'(o_h2u_level[c*LVL_W +: LVL_W]), 64'(hs));
        check("h2u_afull", c, 64'(o_h2u_afull[c]), 64'(hs >= AFULL_TH));
        check("u2h_ack",   c, 64'(o_ul_str_ack[c]),          64'(open && us < DEPTH));
        check("u2h_valid", c, 64'(o_pcie_str_data_valid[c]), 64'(open && us > 0));
        if (open && us > 0) check("u2h_data", c, o_pcie_str_data[c*DATA_W +: DATA_W], mq_u2h[c][0]);
        check("u2h_level", c, 64'(o_u2h_level[c*LVL_W +: LVL_W]), 64'(us));
        check("u2h_afull", c, 64'(o_u2h_afull[c]), 64'(us >= AFULL_TH));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycles(input int n, input int vpct, input int apct, input int flpct, input int enpct);
    repeat (n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!pv[c] || acc_p[c]) begin
          pv[c] = ($urandom_range(99) < vpct);
          pd[c*DATA_W +: DATA_W] = {$urandom, $urandom};
        end
        if (!uv[c] || acc_u[c]) begin
          uv[c] = ($urandom_range(99) < vpct);
          ud[c*DATA_W +: DATA_W] = {$urandom, $urandom};
        end
        pa[c]    = ($urandom_range(99) < apct);
        ua[c]    = ($urandom_range(99) < apct);
        flush[c] = ($urandom_range(99) < flpct);
        if ($urandom_range(99) < enpct) en[c] = ~en[c];
      end
      step();
    end
  endtask

  initial begin
    int sent;
    int cyc;
    rst_n = 1'b0; en = '1; flush = '0;
    pv = '1; uv = '1; pa = '1; ua = '1; pd = '0; ud = '0;
    for (int c = 0; c < NUM_CH; c++) m_pops[c] = 0;

    // Reset with every source valid.
    repeat (3) step();
    check("rst_pcie_ack", -1, 64'(o_pcie_str_ack), 64'h0);
    check("rst_ul_ack",   -1, 64'(o_ul_str_ack), 64'h0);
    check("rst_ul_vld",   -1, 64'(o_ul_str_data_valid), 64'h0);
    check("rst_pcie_vld", -1, 64'(o_pcie_str_data_valid), 64'h0);
    check("rst_h2u_lvl",  -1, 64'(o_h2u_level), 64'h0);
    check("rst_afull",    -1, 64'({o_h2u_afull, o_u2h_afull}), 64'h0);
    rst_n = 1'b1; pv = '0; uv = '0; pa = '0; ua = '0;
    step();
    check("rel_pcie_ack", -1, 64'(o_pcie_str_ack), 64'hF);

    // One-cycle latency on channel 0.
    pd[0 +: DATA_W] = 64'hA5A5_0000_0000_0001; pv[0] = 1'b1;
    step();
    pv[0] = 1'b0;
    check("lat_vld",  0, 64'(o_ul_str_data_valid[0]), 64'h1);
    check("lat_data", 0, o_ul_str_data[0 +: DATA_W], 64'hA5A5_0000_0000_0001);
    check("lat_lvl",  0, 64'(o_h2u_level[0 +: LVL_W]), 64'd1);

    // Fill channel 1 to DEPTH.
    for (int i = 0; i < 16; i++) begin
      pv[1] = 1'b1; pd[DATA_W +: DATA_W] = 64'(i + 100);
      step();
      if (i == 10) check("afull_11", 1, 64'(o_h2u_afull[1]), 64'h0);
      if (i == 11) check("afull_12", 1, 64'(o_h2u_afull[1]), 64'h1);
    end
    pv[1] = 1'b0;
    check("full_ack", 1, 64'(o_pcie_str_ack[1]), 64'h0);
    check("full_lvl", 1, 64'(o_h2u_level[LVL_W +: LVL_W]), 64'd16);
    ua[1] = 1'b1;
    step();
    ua[1] = 1'b0;
    check("pop1_ack", 1, 64'(o_pcie_str_ack[1]), 64'h1);
    check("pop1_lvl", 1, 64'(o_h2u_level[LVL_W +: LVL_W]), 64'd15);

    // Wrap and order: 40 words user->host on channel 2 with random engine ack.
    flush = 4'b0100; step(); flush = '0;
    out2.delete();
    sent = 0; cyc = 0;
    while ((sent < 40 || out2.size() < 40) && cyc < 1000) begin
      uv[2] = (sent < 40);
      ud[2*DATA_W +: DATA_W] = 64'(sent);
      pa[2] = $urandom_range(1);
      step();
      if (acc_u[2]) sent++;
      cyc++;
    end
    uv[2] = 1'b0; pa[2] = 1'b0;
    check("wrap_count", 2, 64'(out2.size()), 64'd40);
    for (int i = 0; i < 40 && i < out2.size(); i++)
      if (out2[i] != 64'(i)) check("wrap_order", 2, out2[i], 64'(i));

    // Flush and enable on channel 3.
    for (int i = 0; i < 5; i++) begin
      pv[3] = 1'b1; pd[3*DATA_W +: DATA_W] = 64'(i + 500); step();
    end
    pv[3] = 1'b0; flush[3] = 1'b1; #1;
    check("fl_vld", 3, 64'(o_ul_str_data_valid[3]), 64'h0);
    step(); flush[3] = 1'b0;
    check("fl_lvl", 3, 64'(o_h2u_level[3*LVL_W +: LVL_W]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      pv[3] = 1'b1; pd[3*DATA_W +: DATA_W] = 64'(i + 600); step();
    end
    pv[3] = 1'b0; en[3] = 1'b0; ua[3] = 1'b1;
    repeat (3) step();
    check("dis_lvl", 3, 64'(o_h2u_level[3*LVL_W +: LVL_W]), 64'd5);
    check("dis_vld", 3, 64'(o_ul_str_data_valid[3]), 64'h0);
    en[3] = 1'b1;
    repeat (5) step();
    check("drain_lvl", 3, 64'(o_h2u_level[3*LVL_W +: LVL_W]), 64'd0);
    ua[3] = 1'b0;

    // Randomized traffic with occasional flush and enable toggles.
    rand_cycles(2000, 70, 60, 1, 3);
    en = '1; flush = '1; pv = '0; uv = '0;
    step();
    flush = '0;
    rand_cycles(1000, 90, 40, 0, 0);

    // Isolation: channel 2 consumer stalled while others stream.
    flush = '1; pv = '0; uv = '0; step(); flush = '0;
    for (int c = 0; c < NUM_CH; c++) m_pops[c] = 0;
    pv = '1; ua = 4'b1011; pa = '0; uv = '0;
    for (int i = 0; i < 101; i++) begin
      for (int c = 0; c < NUM_CH; c++) pd[c*DATA_W +: DATA_W] = 64'((c << 16) + i);
      step();
    end
    pv = '0;
    check("iso_pops0", 0, 64'(m_pops[0]), 64'd100);
    check("iso_pops3", 3, 64'(m_pops[3]), 64'd100);
    check("iso_lvl0",  0, 64'(o_h2u_level[0 +: LVL_W]), 64'd1);
    check("iso_lvl2",  2, 64'(o_h2u_level[2*LVL_W +: LVL_W]), 64'd16);

    // Reset mid-stream discards buffered words.
    ua = '0;
    for (int c = 0; c < NUM_CH; c++) pd[c*DATA_W +: DATA_W] = 64'(c);
    pv = '1; step(); pv = '0;
    rst_n = 1'b0; step();
    check("mrst_ack", -1, 64'(o_pcie_str_ack), 64'h0);
    rst_n = 1'b1; step();
    check("mrst_lvl", -1, 64'(o_h2u_level), 64'h0);
    check("mrst_ack2", -1, 64'(o_pcie_str_ack), 64'hF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/user_stream_adapter_mc.md
Name: user_stream_adapter_mc

Overview:
Parametrised, single-clock stream adapter between the PCIe stream engine and user logic, with NUM_CH independent channels in each direction.
- Each channel and direction owns a first-word-fall-through FIFO of DEPTH words.
- Each channel has an enable and a synchronous flush.
- Occupancy level and almost-full status are exported per FIFO.
- Sits between the PCIe stream ports and the user_logic core inside user_logic_top. It replaces the fixed 4-channel, 64-bit adapter.

Parameters:
NUM_CH, 4, number of stream channels (1..8)
DATA_W, 64, stream word width in bits
DEPTH, 16, words per FIFO; power of two, >= 2
AFULL_TH, 12, level at or above which the almost-full flag is asserted (1..DEPTH)
LVL_W, clog2(DEPTH)+1, derived; width of one level field; not overridable

Ports:
i_user_clk  in  1  sole clock; all logic on rising edge
i_rst  in  1  synchronous, active-low reset
i_ch_enable  in  NUM_CH  per-channel enable
i_ch_flush  in  NUM_CH  per-channel synchronous flush of both FIFOs
i_pcie_str_data_valid  in  NUM_CH  host->user words valid
o_pcie_str_ack  out  NUM_CH  host->user accept
i_pcie_str_data  in  NUM_CH*DATA_W  host->user data; channel k at [k*DATA_W +: DATA_W]
o_pcie_str_data_valid  out  NUM_CH  user->host words valid
i_pcie_str_ack  in  NUM_CH  user->host accept from engine
o_pcie_str_data  out  NUM_CH*DATA_W  user->host data
o_ul_str_data_valid  out  NUM_CH  host->user words to user logic
i_ul_str_ack  in  NUM_CH  user logic accept
o_ul_str_data  out  NUM_CH*DATA_W  host->user data to user logic
i_ul_str_data_valid  in  NUM_CH  user->host words from user logic
o_ul_str_ack  out  NUM_CH  accept toward user logic
i_ul_str_data  in  NUM_CH*DATA_W  user->host data from user logic
o_h2u_level  out  NUM_CH*LVL_W  host->user FIFO occupancy
o_u2h_level  out  NUM_CH*LVL_W  user->host FIFO occupancy
o_h2u_afull  out  NUM_CH  host->user level >= AFULL_TH
o_u2h_afull  out  NUM_CH  user->host level >= AFULL_TH

Behaviour:
- Transfer rule: a word moves on a port when its valid and ack are both high in the same cycle. Valid may not depend on ack. Data is held while valid is high and ack is low.
- Per FIFO, for channel k:
  - Input ack = en[k] & !flush[k] & (level != DEPTH).
  - Output valid = en[k] & !flush[k] & (level != 0).
  - Output data = head word (FWFT).
- Latency: a word accepted at edge t is presented on the output side after edge t, i.e. valid in cycle t+1. Minimum 1 cycle; there is no combinational input->output path.
- Push and pop in the same cycle: level unchanged, order preserved. The full case cannot occur because ack is low when full.
- Empty: output valid is low, and output data is don't-care (implementation holds the last RAM read).
- Full: input ack is low. There is no overflow or underflow by construction.
- Pointers are LVL_W-1 bits and wrap modulo DEPTH. Level is the registered count, 0..DEPTH inclusive.
- afull is registered from the next-state level, so it is coincident with the level output.
- Enable low:
  - Both acks and both valids of that channel are forced low.
  - FIFO contents and level are retained.
  - Traffic resumes in order when re-enabled.
- Flush high in cycle t:
  - Acks and valids of that channel are low in cycle t.
  - Both pointers and the level clear at edge t.
  - Flush overrides enable.
  - Other channels are unaffected.
- Reset (i_rst=0 at an edge):
  - All pointers and levels go to 0; all afull go to 0.
  - All o_*valid and o_*ack are 0 from the first cycle after the reset edge.
  - A reset asserted mid-stream discards buffered words.
- Channels are fully independent: backpressure on one channel never stalls another.

Decomposition:
- Package user_stream_pkg: clog2 function, LVL_W derivation, and a DATA_W default constant shared with user_logic_top.
- Sub-module stream_fifo_fwft (DATA_W, DEPTH, AFULL_TH):
  - Inputs: clk, synchronous active-low reset, enable, flush.
  - Push side: valid/ack/data. Pop side: valid/ack/data.
  - Outputs: level and afull.
  - Instantiated 2*NUM_CH times in a generate loop.
- The top only slices the flattened buses.

Test Plan:
1. Reset: hold i_rst=0 for 3 cycles with all inputs valid=1 -> all acks, valids, levels and afull are 0. Release; with en=all 1, acks go to 1 next cycle.
2. Latency: push 0xA5A5_0000_0000_0001 on channel 0 host->user at edge t -> o_ul_str_data_valid[0]=1 with that word in cycle t+1, and o_h2u_level[0]=1.
3. Fill: i_ul_str_ack[1]=0; push 16 words on channel 1 -> o_pcie_str_ack[1]=0 after word 16, level=16, afull asserted when level reaches 12. Pop one word -> ack returns and level=15.
4. Wrap and order: channel 2 user->host, DEPTH=16, 40 incrementing words with random i_pcie_str_ack -> 40 words out in order 0..39, none lost or duplicated.
5. Flush and enable: with 5 words buffered on channel 3, pulse flush for 1 cycle -> level=0 and valid=0. Separately, with en[3]=0 and 5 words buffered, level stays 5 and valid stays 0. Set en[3]=1 -> the 5 words drain in order.
6. Isolation (NUM_CH=4): channel 2 output held at ack=0 while channels 0, 1 and 3 stream 100 words each -> channels 0, 1 and 3 complete at 1 word/cycle; channel 2 stalls at level=16.
